// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage instruction fields in, stall/forward decisions and stall count out
interface hazard_scoreboard_if #(
  parameter int NSTAGE = 3,
  parameter int SELW = $clog2(NSTAGE + 1)
);
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_rs1_read;
  logic            id_rs2_read;
  logic [4:0]      id_rd;
  logic            id_rf_we;
  logic            id_is_load;
  logic            flush;
  logic            stall;
  logic [SELW-1:0] fwd_sel_rs1;
  logic [SELW-1:0] fwd_sel_rs2;
  logic [31:0]     stall_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_read, id_rs2_read, id_rd, id_rf_we, id_is_load, flush,
    input  stall, fwd_sel_rs1, fwd_sel_rs2, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_read, id_rs2_read, id_rd, id_rf_we, id_is_load, flush,
    output stall, fwd_sel_rs1, fwd_sel_rs2, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard detector tracking in-flight writers in its own shift-register scoreboard
module hazard_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int FWD_EN = 1,
  parameter int LOAD_STAGE = 2,
  parameter int RF_BYPASS = 0
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave hz
);
  localparam int SELW = $clog2(NSTAGE + 1);
  localparam int NLIM = (RF_BYPASS != 0) ? NSTAGE - 1 : NSTAGE;
  localparam logic [SELW-1:0] LS = SELW'(LOAD_STAGE);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } entry_t;
  entry_t          e_q [1:NSTAGE];
  entry_t          e_d [1:NSTAGE];
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [SELW-1:0] k1, k2;
  logic            l1, l2, h1, h2, stall;
  // scan oldest to youngest so the lowest matching stage wins
  always_comb begin
    k1 = '0;
    k2 = '0;
    l1 = 1'b0;
    l2 = 1'b0;
    for (int k = NLIM; k >= 1; k--) begin
      if (hz.id_rs1_read && hz.id_rs1 != 5'd0 && e_q[k].v && e_q[k].we && e_q[k].rd == hz.id_rs1) begin
        k1 = SELW'(k);
        l1 = e_q[k].ld;
      end
      if (hz.id_rs2_read && hz.id_rs2 != 5'd0 && e_q[k].v && e_q[k].we && e_q[k].rd == hz.id_rs2) begin
        k2 = SELW'(k);
        l2 = e_q[k].ld;
      end
    end
    h1 = k1 != '0 && (FWD_EN == 0 || (l1 && k1 < LS));
    h2 = k2 != '0 && (FWD_EN == 0 || (l2 && k2 < LS));
    stall = hz.id_valid && !hz.flush && (h1 || h2);
    e_d[1] = {hz.id_valid && !stall && !hz.flush, hz.id_rd, hz.id_rf_we, hz.id_is_load};
    for (int k = 2; k <= NSTAGE; k++) e_d[k] = e_q[k-1];
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= NSTAGE; k++) e_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q <= e_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign hz.stall = stall;
  assign hz.fwd_sel_rs1 = (FWD_EN != 0 && !stall) ? k1 : '0;
  assign hz.fwd_sel_rs2 = (FWD_EN != 0 && !stall) ? k2 : '0;
  assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors on a forwarding instance plus stall-only sequences
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.NSTAGE(3)) ia ();
  hazard_scoreboard_if #(.NSTAGE(3)) ib ();
  hazard_scoreboard #(.NSTAGE(3), .FWD_EN(1), .LOAD_STAGE(2), .RF_BYPASS(0)) dut_a (.clk(clk), .rst(rst), .hz(ia));
  hazard_scoreboard #(.NSTAGE(3), .FWD_EN(0), .LOAD_STAGE(2), .RF_BYPASS(0)) dut_b (.clk(clk), .rst(rst), .hz(ib));
  typedef struct {
    logic vld; logic [4:0] rs1; logic r1; logic [4:0] rs2; logic r2;
    logic [4:0] rd; logic we; logic ld; logic fl;
    logic x_stall; logic [1:0] x_s1; logic [1:0] x_s2; logic [31:0] x_cnt;
  } vec_t;
  vec_t tv [19];
  function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic r1, input logic [4:0] rs2,
      input logic r2, input logic [4:0] rd, input logic we, input logic ld, input logic fl,
      input logic xs, input logic [1:0] x1, input logic [1:0] x2, input logic [31:0] xc);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.r1 = r1; v.rs2 = rs2; v.r2 = r2; v.rd = rd; v.we = we; v.ld = ld; v.fl = fl;
    v.x_stall = xs; v.x_s1 = x1; v.x_s2 = x2; v.x_cnt = xc;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic drive_a(input vec_t v);
    ia.id_valid = v.vld; ia.id_rs1 = v.rs1; ia.id_rs1_read = v.r1; ia.id_rs2 = v.rs2; ia.id_rs2_read = v.r2;
    ia.id_rd = v.rd; ia.id_rf_we = v.we; ia.id_is_load = v.ld; ia.flush = v.fl;
  endtask
  task automatic drive_b(input logic vld, input logic [4:0] rs1, input logic r1, input logic [4:0] rs2,
      input logic r2, input logic [4:0] rd);
    ib.id_valid = vld; ib.id_rs1 = rs1; ib.id_rs1_read = r1; ib.id_rs2 = rs2; ib.id_rs2_read = r2;
    ib.id_rd = rd; ib.id_rf_we = 1'b1; ib.id_is_load = 1'b0; ib.flush = 1'b0;
  endtask
  task automatic stall_run(input string nm, input int exp);
    int n = 0;
    while (ib.stall && n < 10) begin
      n++;
      @(negedge clk); #1;
    end
    chk(nm, n, exp);
  endtask
  task automatic drain_b;
    drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    tv[0]  = mk(1,  1,1,  2,1,  5,1,0,0, 0,0,0,0);
    tv[1]  = mk(1,  5,1,  5,1,  6,1,0,0, 0,1,1,0);
    tv[2]  = mk(1,  5,1,  6,1,  9,1,0,0, 0,2,1,0);
    tv[3]  = mk(1,  5,1,  0,1, 10,1,0,0, 0,3,0,0);
    tv[4]  = mk(1,  1,1,  0,0,  7,1,1,0, 0,0,0,0);
    tv[5]  = mk(1,  7,1,  1,1,  8,1,0,0, 1,0,0,0);
    tv[6]  = mk(1,  7,1,  1,1,  8,1,0,0, 0,2,0,1);
    tv[7]  = mk(1,  1,1,  0,0,  0,1,0,0, 0,0,0,1);
    tv[8]  = mk(1,  0,1,  0,1, 11,1,0,0, 0,0,0,1);
    tv[9]  = mk(1, 11,0,  0,0, 12,1,0,0, 0,0,0,1);
    tv[10] = mk(1,  2,1,  0,0, 13,1,1,0, 0,0,0,1);
    tv[11] = mk(1, 13,1, 13,1, 14,1,0,1, 0,1,1,1);
    tv[12] = mk(1, 14,1, 13,1, 15,1,0,0, 0,0,2,1);
    tv[13] = mk(1,  0,0,  0,0, 20,1,0,0, 0,0,0,1);
    tv[14] = mk(1,  0,0,  0,0, 20,1,0,0, 0,0,0,1);
    tv[15] = mk(1, 20,1, 20,1, 21,1,0,0, 0,1,1,1);
    tv[16] = mk(1,  1,1,  0,0, 22,1,1,0, 0,0,0,1);
    tv[17] = mk(1,  1,1, 22,1, 23,1,0,0, 1,0,0,1);
    tv[18] = mk(1,  1,1, 22,1, 23,1,0,0, 0,0,2,2);
    drive_a(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0));
    drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    drive_a(mk(1, 5,1, 6,1, 7,1,0,0, 0,0,0,0));
    #1;
    chk("a_rst_stall", ia.stall, 0);
    chk("a_rst_sel1", ia.fwd_sel_rs1, 0);
    chk("a_rst_cnt", ia.stall_cnt, 0);
    chk("b_rst_cnt", ib.stall_cnt, 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      drive_a(tv[i]);
      #1;
      chk($sformatf("v%0d_stall", i), ia.stall, tv[i].x_stall);
      chk($sformatf("v%0d_sel1", i), ia.fwd_sel_rs1, tv[i].x_s1);
      chk($sformatf("v%0d_sel2", i), ia.fwd_sel_rs2, tv[i].x_s2);
      chk($sformatf("v%0d_cnt", i), ia.stall_cnt, tv[i].x_cnt);
      @(negedge clk);
    end
    drive_b(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3);
    #1; chk("b_prod_stall", ib.stall, 0);
    @(negedge clk); drive_b(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4);
    #1; stall_run("b_dist1_len", 3);
    chk("b_dist1_sel1", ib.fwd_sel_rs1, 0);
    chk("b_dist1_cnt", ib.stall_cnt, 3);
    @(negedge clk); drain_b;
    drive_b(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3);
    @(negedge clk); drive_b(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9);
    @(negedge clk); drive_b(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4);
    #1; stall_run("b_dist2_len", 2);
    chk("b_dist2_cnt", ib.stall_cnt, 5);
    @(negedge clk); drain_b;
    drive_b(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3);
    @(negedge clk); drive_b(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4);
    #1; chk("b_pre_rst_stall", ib.stall, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("b_post_rst_stall", ib.stall, 0);
    chk("b_post_rst_cnt", ib.stall_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
